adder_response_checker: RTL and testbench
=========================================

# adder_response_checker

Synthesizable response checker for the 4-bit carry-select adder. It sits on the DUT output side, the counterpart of the random stimulus driver. It accepts operand/result tuples through a valid/ready handshake and recomputes the expected sum and carry. It keeps saturating pass/fail counts and captures the first mismatching tuple for readback, so the adder can be verified on-chip or in a self-checking bench.

## Interface
- WIDTH, 4, operand and sum width
- CNT_W, 16, width of the pass and fail counters
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start_in  input  1  one-cycle pulse: clear counts and capture, enter RUN
- stop_in  input  1  one-cycle pulse: end the run, drain the pipeline, enter DONE
- valid_in  input  1  tuple on a_in..carry_in is valid
- a_in  input  WIDTH  operand A applied to the DUT
- b_in  input  WIDTH  operand B applied to the DUT
- c_in  input  1  carry-in applied to the DUT
- sum_in  input  WIDTH  DUT sum_out
- carry_in  input  1  DUT carry_out
- ready_out  output  1  checker accepts tuples (RUN only)
- busy_out  output  1  state is RUN or DRAIN
- done_out  output  1  state is DONE
- pass_cnt_out  output  CNT_W  matching tuples, saturating
- fail_cnt_out  output  CNT_W  mismatching tuples, saturating
- fail_flag_out  output  1  sticky: at least one mismatch since start
- fail_vec_out  output  3*WIDTH+2  first failing tuple {a, b, c, sum, carry}

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start_in goes to RUN.
  - RUN: stop_in goes to DRAIN.
  - DRAIN: goes to DONE once the compare stage is empty (one cycle if a tuple is in flight, otherwise the next cycle).
  - DONE: start_in goes to RUN.
- start_in in RUN or DRAIN is ignored. stop_in outside RUN is ignored.
- On entering RUN:
  - pass_cnt_out, fail_cnt_out, fail_flag_out and fail_vec_out clear to 0.
  - The compare stage is flushed.
- A tuple is accepted when valid_in && ready_out.
- Stage 1 registers the accepted tuple and a stage-valid bit.
- Stage 2 computes expected = a + b + c at WIDTH+1 bits. It compares {carry, sum} against expected[WIDTH:0].
  - Match: pass_cnt increments.
  - Mismatch: fail_cnt increments. If fail_flag_out was 0, the tuple is stored in fail_vec_out and fail_flag_out is set.
- Counters saturate at 2^CNT_W-1 and never wrap.
- fail_vec_out holds only the first failure. Later failures do not overwrite it.
- Outputs hold their values in DONE and IDLE until the next start_in or rst.

## Timing
- Reset values:
  - state = IDLE
  - ready_out = 0, busy_out = 0, done_out = 0
  - pass_cnt_out = 0, fail_cnt_out = 0
  - fail_flag_out = 0, fail_vec_out = 0
  - stage-valid = 0
- rst mid-run aborts immediately. All of the above values apply on the next edge, and any in-flight tuple is discarded.
- ready_out is high in every RUN cycle (full throughput, one tuple per clock) and is low in all other states.
- start_in pulse at edge k: state = RUN and ready_out = 1 after edge k.
- Tuple accepted at edge k is counted at edge k+1. Counts and flag are visible from edge k+1 onward.
- stop_in and valid_in in the same RUN cycle: the tuple is accepted, and it is counted during DRAIN.
- done_out rises at most 2 edges after the stop_in edge. Counts are final when done_out = 1.
- A tuple with valid_in high while ready_out = 0 is ignored, with no count change.

## Configuration
- Macro: CHECKER_STOP_ON_FAIL_EN.
- Defined: a mismatch in stage 2 forces the FSM to DRAIN on the same edge, so ready_out drops the cycle after the failing count. The run ends with fail_cnt_out = 1 and done_out following.
- Not defined: mismatches are counted and the run continues until stop_in.

## Test plan
- Reset then idle: rst for 2 cycles, valid_in = 1 with random tuples, no start -> all outputs 0, ready_out = 0.
- Correct tuples: start, feed a=7 b=8 c=1 sum=0 carry=1, then a=3 b=4 c=0 sum=7 carry=0, stop -> pass_cnt = 2, fail_cnt = 0, fail_flag = 0, done_out = 1 within 2 cycles of stop.
- First-failure capture: start, feed a=5 b=5 c=0 sum=9 carry=0 (bad), then a=1 b=1 c=1 sum=0 carry=0 (bad), then one good tuple, stop -> fail_cnt = 2, pass_cnt = 1, fail_vec = {5, 5, 0, 9, 0}.
- Same-cycle stop: start, valid_in with a good tuple on the same cycle as stop_in -> pass_cnt = 1 after DRAIN, done_out = 1.
- Saturation with CNT_W=2: start, 5 good tuples back-to-back -> pass_cnt = 3, no wrap.
- Reset mid-run and restart: start, 3 tuples, assert rst -> all outputs 0 next cycle. Then start again -> counts begin from 0. With CHECKER_STOP_ON_FAIL_EN defined, the first bad tuple -> ready_out = 0 next cycle, fail_cnt = 1, done_out = 1.

Source files
------------

// File: rtl/adder_response_checker.sv
// adder_response_checker
// Response checker for the 4-bit carry-select adder. Accepts {a, b, c, sum, carry}
// tuples over a valid/ready handshake, recomputes a + b + c one stage later and keeps
// saturating pass/fail counts plus a capture of the first mismatching tuple.
//
// Optional feature macro: CHECKER_STOP_ON_FAIL_EN
//   defined   : the first mismatch ends the run (RUN -> DRAIN on the failing count)
//   undefined : mismatches are counted and the run continues until stop_in
//
// state | meaning
// IDLE  | after reset, outputs hold, waiting for start_in
// RUN   | ready_out high, one tuple accepted per clock
// DRAIN | input closed, last in-flight tuple is being counted
// DONE  | counts final, outputs hold until next start_in
module adder_response_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic                 stop_in,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 c_in,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic                 carry_in,
  output logic                 ready_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [CNT_W-1:0]     pass_cnt_out,
  output logic [CNT_W-1:0]     fail_cnt_out,
  output logic                 fail_flag_out,
  output logic [3*WIDTH+1:0]   fail_vec_out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_c;
  logic [WIDTH-1:0] s1_sum;
  logic             s1_carry;
  logic [WIDTH:0]   expected;
  logic             s1_match;
  logic             accept;

  assign accept = valid_in && ready_out;

  // Stage 2 reference sum and compare against the captured DUT response
  always_comb begin
    expected = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_c};
    s1_match = ({s1_carry, s1_sum} == expected);
  end

  // Capture stage, compare/count stage and run-control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ready_out     <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      pass_cnt_out  <= '0;
      fail_cnt_out  <= '0;
      fail_flag_out <= 1'b0;
      fail_vec_out  <= '0;
      s1_valid      <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_c          <= 1'b0;
      s1_sum        <= '0;
      s1_carry      <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a     <= a_in;
        s1_b     <= b_in;
        s1_c     <= c_in;
        s1_sum   <= sum_in;
        s1_carry <= carry_in;
      end

      if (s1_valid) begin
        if (s1_match) begin
          if (pass_cnt_out != CNT_MAX) pass_cnt_out <= pass_cnt_out + CNT_W'(1);
        end else begin
          if (fail_cnt_out != CNT_MAX) fail_cnt_out <= fail_cnt_out + CNT_W'(1);
          if (!fail_flag_out) begin
            fail_flag_out <= 1'b1;
            fail_vec_out  <= {s1_a, s1_b, s1_c, s1_sum, s1_carry};
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          // Clearing here overrides any count update above (stage is empty anyway)
          if (start_in) begin
            state         <= RUN;
            ready_out     <= 1'b1;
            busy_out      <= 1'b1;
            done_out      <= 1'b0;
            pass_cnt_out  <= '0;
            fail_cnt_out  <= '0;
            fail_flag_out <= 1'b0;
            fail_vec_out  <= '0;
            s1_valid      <= 1'b0;
          end
        end
        RUN: begin
          if (stop_in) begin
            state     <= DRAIN;
            ready_out <= 1'b0;
          end
`ifdef CHECKER_STOP_ON_FAIL_EN
          // The tuple accepted alongside the failing count is dropped so the run
          // ends with exactly one failure recorded.
          if (s1_valid && !s1_match) begin
            state     <= DRAIN;
            ready_out <= 1'b0;
            s1_valid  <= 1'b0;
          end
`endif
        end
        DRAIN: begin
          // The single stage is always consumed on this edge, so one cycle suffices
          state    <= DONE;
          busy_out <= 1'b0;
          done_out <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_response_checker.sv
// Testbench for adder_response_checker: randomized and directed tuples, a queue-based
// scoreboard with an arithmetic reference model, and a CNT_W=2 instance for saturation.
module tb_adder_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic        stop_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [3:0]  a_in = '0;
  logic [3:0]  b_in = '0;
  logic        c_in = 1'b0;
  logic [3:0]  sum_in = '0;
  logic        carry_in = 1'b0;

  logic        ready_out, busy_out, done_out, fail_flag_out;
  logic [15:0] pass_cnt_out, fail_cnt_out;
  logic [13:0] fail_vec_out;

  logic        s_ready, s_busy, s_done, s_flag;
  logic [1:0]  s_pass, s_fail;
  logic [13:0] s_vec;

  adder_response_checker #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .sum_in(sum_in), .carry_in(carry_in),
    .ready_out(ready_out), .busy_out(busy_out), .done_out(done_out),
    .pass_cnt_out(pass_cnt_out), .fail_cnt_out(fail_cnt_out),
    .fail_flag_out(fail_flag_out), .fail_vec_out(fail_vec_out)
  );

  adder_response_checker #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .sum_in(sum_in), .carry_in(carry_in),
    .ready_out(s_ready), .busy_out(s_busy), .done_out(s_done),
    .pass_cnt_out(s_pass), .fail_cnt_out(s_fail),
    .fail_flag_out(s_flag), .fail_vec_out(s_vec)
  );

  typedef struct {
    int         acc_edge;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] sum;
    logic       carry;
  } item_t;

  item_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  int          m_pass = 0;
  int          m_fail = 0;
  logic        m_flag = 1'b0;
  logic [13:0] m_vec  = '0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Scoreboard monitor: a tuple accepted at edge k is reflected in the counts after k+1
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].acc_edge + 1 <= edge_n) begin
      item_t it;
      int    want;
      int    got;
      it   = q.pop_front();
      want = int'(it.a) + int'(it.b) + int'(it.c);
      got  = int'(it.carry) * 16 + int'(it.sum);
      if (want == got) m_pass++;
      else begin
        m_fail++;
        if (!m_flag) begin
          m_flag = 1'b1;
          m_vec  = {it.a, it.b, it.c, it.sum, it.carry};
        end
      end
      chk("sb_pass", 64'(pass_cnt_out), 64'(sat(m_pass, 65535)));
      chk("sb_fail", 64'(fail_cnt_out), 64'(sat(m_fail, 65535)));
      chk("sb_flag", 64'(fail_flag_out), 64'(m_flag));
      chk("sb_vec",  64'(fail_vec_out),  64'(m_vec));
      chk("sb_sat_pass", 64'(s_pass), 64'(sat(m_pass, 3)));
      chk("sb_sat_fail", 64'(s_fail), 64'(sat(m_fail, 3)));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_model();
    q.delete();
    m_pass = 0;
    m_fail = 0;
    m_flag = 1'b0;
    m_vec  = '0;
  endtask

  task automatic idle_in();
    valid_in = 1'b0;
    start_in = 1'b0;
    stop_in  = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int c, input int s, input int co,
                      input bit push);
    item_t it;
    valid_in = 1'b1;
    a_in = 4'(a); b_in = 4'(b); c_in = 1'(c); sum_in = 4'(s); carry_in = 1'(co);
    if (push) begin
      it.acc_edge = edge_n + 1;
      it.a = 4'(a); it.b = 4'(b); it.c = 1'(c); it.sum = 4'(s); it.carry = 1'(co);
      q.push_back(it);
    end
    tick();
  endtask

  task automatic do_start();
    start_in = 1'b1;
    #1 clear_model();
    tick();
    start_in = 1'b0;
    chk("start_ready", 64'(ready_out), 64'd1);
    chk("start_busy",  64'(busy_out),  64'd1);
    chk("start_done",  64'(done_out),  64'd0);
    chk("start_pass",  64'(pass_cnt_out), 64'd0);
  endtask

  task automatic do_stop();
    valid_in = 1'b0;
    stop_in  = 1'b1;
    tick();
    stop_in = 1'b0;
    chk("stop_ready", 64'(ready_out), 64'd0);
    tick();
    chk("stop_done", 64'(done_out), 64'd1);
    chk("stop_busy", 64'(busy_out), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(ready_out), 64'd0);
    chk({tag, "_busy"},  64'(busy_out),  64'd0);
    chk({tag, "_done"},  64'(done_out),  64'd0);
    chk({tag, "_pass"},  64'(pass_cnt_out), 64'd0);
    chk({tag, "_fail"},  64'(fail_cnt_out), 64'd0);
    chk({tag, "_flag"},  64'(fail_flag_out), 64'd0);
    chk({tag, "_vec"},   64'(fail_vec_out),  64'd0);
  endtask

  initial begin
    // Reset then idle with random valid tuples and no start
    rst = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_in = 4'($urandom_range(0, 15)); b_in = 4'($urandom_range(0, 15));
      sum_in = 4'($urandom_range(0, 15)); c_in = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in = 4'($urandom_range(0, 15)); b_in = 4'($urandom_range(0, 15));
      sum_in = 4'($urandom_range(0, 15)); carry_in = 1'($urandom_range(0, 1));
      tick();
    end
    check_all_zero("idle");
    idle_in();
    tick();

    // Correct tuples
    do_start();
    send(7, 8, 1, 0, 1, 1);
    send(3, 4, 0, 7, 0, 1);
    do_stop();
    chk("good_pass", 64'(pass_cnt_out), 64'd2);
    chk("good_fail", 64'(fail_cnt_out), 64'd0);
    chk("good_flag", 64'(fail_flag_out), 64'd0);

`ifndef CHECKER_STOP_ON_FAIL_EN
    // First-failure capture
    do_start();
    send(5, 5, 0, 9, 0, 1);
    send(1, 1, 1, 0, 0, 1);
    send(2, 3, 0, 5, 0, 1);
    do_stop();
    chk("ff_fail", 64'(fail_cnt_out), 64'd2);
    chk("ff_pass", 64'(pass_cnt_out), 64'd1);
    chk("ff_flag", 64'(fail_flag_out), 64'd1);
    chk("ff_vec",  64'(fail_vec_out), 64'({4'd5, 4'd5, 1'b0, 4'd9, 1'b0}));
`else
    // Stop on first failure
    do_start();
    send(5, 5, 0, 9, 0, 1);
    send(2, 3, 0, 5, 0, 0);
    chk("sof_ready", 64'(ready_out), 64'd0);
    chk("sof_fail",  64'(fail_cnt_out), 64'd1);
    chk("sof_busy",  64'(busy_out), 64'd1);
    send(1, 2, 0, 3, 0, 0);
    valid_in = 1'b0;
    chk("sof_done",  64'(done_out), 64'd1);
    chk("sof_fail2", 64'(fail_cnt_out), 64'd1);
    chk("sof_pass",  64'(pass_cnt_out), 64'd0);
    chk("sof_vec",   64'(fail_vec_out), 64'({4'd5, 4'd5, 1'b0, 4'd9, 1'b0}));
    tick();
`endif

    // Same-cycle stop and valid
    do_start();
    stop_in = 1'b1;
    send(9, 6, 1, 0, 1, 1);
    stop_in = 1'b0;
    valid_in = 1'b0;
    chk("sc_busy", 64'(busy_out), 64'd1);
    chk("sc_done", 64'(done_out), 64'd0);
    tick();
    chk("sc_done2", 64'(done_out), 64'd1);
    chk("sc_pass",  64'(pass_cnt_out), 64'd1);

    // Saturation on the CNT_W=2 instance
    do_start();
    for (int i = 0; i < 5; i++) begin
      int a, b, c, t;
      a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 1);
      t = a + b + c;
      send(a, b, c, t % 16, t / 16, 1);
    end
    do_stop();
    chk("sat_pass2",  64'(s_pass), 64'd3);
    chk("sat_fail2",  64'(s_fail), 64'd0);
    chk("sat_pass16", 64'(pass_cnt_out), 64'd5);

    // Randomized run
    do_start();
    for (int i = 0; i < 60; i++) begin
      int a, b, c, t;
      a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 1);
      t = a + b + c;
`ifndef CHECKER_STOP_ON_FAIL_EN
      if ($urandom_range(0, 3) == 0) t = t ^ int'($urandom_range(1, 31));
`endif
      if ($urandom_range(0, 4) != 0) send(a, b, c, t % 16, t / 16, 1);
      else begin
        valid_in = 1'b0;
        tick();
      end
    end
    do_stop();
    chk("rnd_pass", 64'(pass_cnt_out), 64'(m_pass));
    chk("rnd_fail", 64'(fail_cnt_out), 64'(m_fail));
    chk("rnd_flag", 64'(fail_flag_out), 64'(m_flag));
    chk("rnd_vec",  64'(fail_vec_out), 64'(m_vec));

    // Reset mid-run with a tuple in flight, then restart
    do_start();
    send(1, 2, 0, 3, 0, 1);
    send(4, 4, 1, 9, 0, 1);
    send(8, 8, 0, 0, 1, 1);
    valid_in = 1'b0;
    rst = 1'b1;
    #1 clear_model();
    tick();
    check_all_zero("rstmid");
    chk("rstmid_sat_pass", 64'(s_pass), 64'd0);
    rst = 1'b0;
    tick();
    do_start();
    send(6, 7, 1, 14, 0, 1);
    do_stop();
    chk("restart_pass", 64'(pass_cnt_out), 64'd1);
    chk("restart_fail", 64'(fail_cnt_out), 64'd0);
    tick();
    chk("hold_done", 64'(done_out), 64'd1);
    chk("hold_pass", 64'(pass_cnt_out), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
